// File: rtl/gin.sv
// gin: global input network; scatters one tagged GLB word to every PE whose scanned (Y, X) IDs match.
// A single holding register keeps the word until each targeted PE has handshaked.
module gin #(
    parameter int NUMS_PE_ROW = 6,
    parameter int NUMS_PE_COL = 8,
    parameter int XID_BITS    = 5,
    parameter int YID_BITS    = 5,
    parameter int DATA_BITS   = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       GIN_valid,
    output logic                                       GIN_ready,
    input  logic [DATA_BITS-1:0]                       GIN_data,
    input  logic [XID_BITS-1:0]                        tag_X,
    input  logic [YID_BITS-1:0]                        tag_Y,
    input  logic                                       set_XID,
    input  logic [XID_BITS-1:0]                        XID_scan_in,
    input  logic                                       set_YID,
    input  logic [YID_BITS-1:0]                        YID_scan_in,
    output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           PE_valid,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           PE_ready,
    output logic [DATA_BITS*NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_data,
    output logic                                       GIN_miss
);
    localparam int N = NUMS_PE_ROW * NUMS_PE_COL;

    logic [YID_BITS-1:0]  r_yid [NUMS_PE_ROW];
    logic [XID_BITS-1:0]  r_xid [N];
    logic                 r_full;
    logic                 r_miss;
    logic [N-1:0]         r_pending;
    logic [DATA_BITS-1:0] r_hold;
    logic [N-1:0]         w_target;
    logic [N-1:0]         w_left;
    logic                 w_accept;

    for (genvar p = 0; p < N; p++) begin : g_tgt
        assign w_target[p] = (r_yid[p / NUMS_PE_COL] == tag_Y) && (r_xid[p] == tag_X);
    end

    assign GIN_ready = ~r_full & ~rst;
    assign w_accept  = GIN_valid & GIN_ready;
    assign w_left    = r_pending & ~PE_ready;
    assign PE_valid  = r_full ? r_pending : '0;
    assign PE_data   = {N{r_hold}};
    assign GIN_miss  = r_miss;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_yid     <= '{default: '0};
            r_xid     <= '{default: '0};
            r_full    <= 1'b0;
            r_miss    <= 1'b0;
            r_pending <= '0;
            r_hold    <= '0;
        end else begin
            if (set_YID) begin
                for (int i = 0; i < NUMS_PE_ROW - 1; i++) r_yid[i] <= r_yid[i+1];
                r_yid[NUMS_PE_ROW-1] <= YID_scan_in;
            end
            if (set_XID) begin
                for (int i = 0; i < N - 1; i++) r_xid[i] <= r_xid[i+1];
                r_xid[N-1] <= XID_scan_in;
            end
            // An unmatched word is consumed in one cycle and flagged instead of blocking the GLB.
            r_miss <= w_accept & ~|w_target;
            if (w_accept) begin
                r_hold    <= GIN_data;
                r_pending <= w_target;
                r_full    <= |w_target;
            end else if (r_full) begin
                r_pending <= w_left;
                r_full    <= |w_left;
            end
        end
    end
endmodule

// File: tb/tb_gin.sv
// tb_gin: directed-vector bench for gin with hand-computed expectations.
module tb_gin;
    localparam int R = 6;
    localparam int N = 48;

    logic            clk = 1'b0;
    logic            rst;
    logic            GIN_valid;
    logic            GIN_ready;
    logic [31:0]     GIN_data;
    logic [4:0]      tag_X;
    logic [4:0]      tag_Y;
    logic            set_XID;
    logic [4:0]      XID_scan_in;
    logic            set_YID;
    logic [4:0]      YID_scan_in;
    logic [N-1:0]    PE_valid;
    logic [N-1:0]    PE_ready;
    logic [32*N-1:0] PE_data;
    logic            GIN_miss;
    int              n_chk = 0;
    int              n_err = 0;

    always #5 clk = ~clk;

    gin dut (
        .clk(clk), .rst(rst), .GIN_valid(GIN_valid), .GIN_ready(GIN_ready), .GIN_data(GIN_data),
        .tag_X(tag_X), .tag_Y(tag_Y), .set_XID(set_XID), .XID_scan_in(XID_scan_in),
        .set_YID(set_YID), .YID_scan_in(YID_scan_in), .PE_valid(PE_valid), .PE_ready(PE_ready),
        .PE_data(PE_data), .GIN_miss(GIN_miss)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pe_word(input int p);
        return PE_data[p*32 +: 32];
    endfunction

    initial begin
        rst = 1; GIN_valid = 1; GIN_data = 32'h12345678; tag_X = 0; tag_Y = 0;
        set_XID = 0; set_YID = 0; XID_scan_in = 0; YID_scan_in = 0; PE_ready = '1;
        repeat (3) begin
            tick;
            check("rst_ready", GIN_ready, 0);
            check("rst_valid", PE_valid, 0);
        end
        check("rst_data", pe_word(0), 0);
        check("rst_miss", GIN_miss, 0);
        rst = 0; GIN_valid = 0; #1;
        check("post_rst_ready", GIN_ready, 1);
        check("post_rst_valid", PE_valid, 0);

        // YID[r] = r, XID[p] = p % 8
        for (int i = 0; i < N; i++) begin
            set_XID = 1; XID_scan_in = 5'(i % 8);
            set_YID = (i < R); YID_scan_in = 5'(i);
            tick;
        end
        set_XID = 0; set_YID = 0;

        // unicast to PE (2,3)
        GIN_valid = 1; GIN_data = 32'hDEADBEEF; tag_Y = 2; tag_X = 3; #1;
        check("uni_ready", GIN_ready, 1);
        tick; GIN_valid = 0;
        check("uni_valid", PE_valid, 64'h80000);
        check("uni_data", pe_word(19), 32'hDEADBEEF);
        check("uni_busy", GIN_ready, 0);
        tick;
        check("uni_done_ready", GIN_ready, 1);
        check("uni_done_valid", PE_valid, 0);

        // row 1 all X=7
        for (int i = 0; i < N; i++) begin
            set_XID = 1; XID_scan_in = (i / 8 == 1) ? 5'd7 : 5'(i % 8);
            tick;
        end
        set_XID = 0;

        PE_ready = '0; GIN_valid = 1; GIN_data = 32'hA5A50001; tag_Y = 1; tag_X = 7;
        tick; GIN_valid = 0;
        check("mc_valid1", PE_valid, 64'hFF00);
        PE_ready = 48'h0F00;
        tick;
        check("mc_valid2", PE_valid, 64'hF000);
        check("mc_data2", pe_word(12), 32'hA5A50001);
        tick;
        check("mc_valid3", PE_valid, 64'hF000);
        check("mc_busy3", GIN_ready, 0);
        tick;
        check("mc_valid4", PE_valid, 64'hF000);
        check("mc_data4", pe_word(15), 32'hA5A50001);
        PE_ready = '1;
        tick;
        check("mc_done_valid", PE_valid, 0);
        check("mc_done_ready", GIN_ready, 1);

        // misses
        GIN_valid = 1; GIN_data = 32'h0BAD0001; tag_Y = 31; tag_X = 0;
        tick; GIN_valid = 0;
        check("miss_pulse", GIN_miss, 1);
        check("miss_valid", PE_valid, 0);
        check("miss_ready", GIN_ready, 1);
        tick;
        check("miss_clear", GIN_miss, 0);
        GIN_valid = 1;
        for (int i = 0; i < 3; i++) begin
            check("miss3_ready", GIN_ready, 1);
            tick;
            check("miss3_pulse", GIN_miss, 1);
            check("miss3_valid", PE_valid, 0);
        end
        GIN_valid = 0;
        tick;
        check("miss3_end", GIN_miss, 0);

        // backpressure with an ID shift while busy
        PE_ready = '0; GIN_valid = 1; GIN_data = 32'h11111111; tag_Y = 2; tag_X = 3;
        tick;
        GIN_data = 32'h22222222; set_XID = 1; XID_scan_in = 0;
        check("bp_ready", GIN_ready, 0);
        check("bp_valid", PE_valid, 64'h80000);
        tick; set_XID = 0;
        check("bp_hold", pe_word(19), 32'h11111111);
        check("bp_valid2", PE_valid, 64'h80000);
        check("bp_ready2", GIN_ready, 0);
        PE_ready = '1;
        tick;
        check("bp_free", GIN_ready, 1);
        check("bp_idle", PE_valid, 0);
        tick; GIN_valid = 0;
        check("bp_new_valid", PE_valid, 64'h40000);
        check("bp_new_data", pe_word(18), 32'h22222222);
        tick;
        check("bp_new_done", GIN_ready, 1);

        // reset while 4 PEs pending
        PE_ready = '0; GIN_valid = 1; GIN_data = 32'h33333333; tag_Y = 1; tag_X = 7;
        tick; GIN_valid = 0;
        check("rm_valid1", PE_valid, 64'h7F00);
        PE_ready = 48'h0700;
        tick;
        check("rm_valid2", PE_valid, 64'h7800);
        PE_ready = '0; rst = 1;
        tick;
        check("rm_valid", PE_valid, 0);
        check("rm_data", pe_word(11), 0);
        check("rm_ready", GIN_ready, 0);
        rst = 0; GIN_valid = 1; GIN_data = 32'hCAFEF00D; tag_X = 0; tag_Y = 0; #1;
        check("rm_ready2", GIN_ready, 1);
        tick; GIN_valid = 0;
        check("rm_all", PE_valid, 64'hFFFF_FFFF_FFFF);
        check("rm_data0", pe_word(0), 32'hCAFEF00D);
        check("rm_data47", pe_word(47), 32'hCAFEF00D);
        PE_ready = '1;
        tick;
        check("rm_done", GIN_ready, 1);
        check("rm_done_valid", PE_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
